queue_issue_select: RTL and testbench
=====================================

Name: queue_issue_select

Overview:
- Select stage directly downstream of the issue-queue slots.
- Each cycle it picks one requesting slot round-robin and drives a one-hot grant back to the slots; the granted slot clears its own valid bits.
- The chosen slot's read word is latched into an output issue register, which feeds register read/execute through a valid/ready handshake.
- Held entries are squashed on branch kill.

Parameters:
- NSLOT, 8, number of queue slots (power of two, ≥2).
- WIDTH_REG, 5, register index width.
- WIDTH_TAG, 3, ROB tag width.
- WIDTH_BRM, 3, branch-mask width.
- WIDTH_O, WIDTH_BRM+WIDTH_TAG+3*WIDTH_REG+2, slot read word {BrMask, Tag, RD, RT, RS, val[1:0]}.
- WIDTH_IDX, $clog2(NSLOT), slot index width.

Ports:
- i_clk, input, 1, clock; all state updates on posedge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_request, input, NSLOT, per-slot request flags.
- i_rslot, input, NSLOT*WIDTH_O, per-slot read words; slot k occupies bits [(k+1)*WIDTH_O-1 : k*WIDTH_O].
- i_brkill, input, 2**WIDTH_BRM, branch-kill vector; an entry with mask m is killed when i_brkill[m]=1.
- i_ready, input, 1, downstream accepts the issue register this cycle.
- o_grant, output, NSLOT, one-hot (or zero) grant to the slots; combinational.
- o_valid, output, 1, issue register holds a valid uop; registered.
- o_uop, output, WIDTH_O, issued slot word; registered.
- o_idx, output, WIDTH_IDX, slot index the held uop came from; registered.

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, o_uop=0, o_idx=0, round-robin pointer ptr=0. o_grant is 0 while o_valid=0 and no requests.
- eligible[k] = i_request[k] & ~i_brkill[BrMask_k]. A slot killed this cycle is never granted.
- Load enable: load = ~o_valid | i_ready. The register is free, or draining this cycle.
- Arbitration:
  - Search eligible from index ptr upward, wrapping modulo NSLOT.
  - The first set bit g wins.
  - o_grant = onehot(g) when load & |eligible; otherwise 0.
  - At most one grant bit is ever set.
- Posedge, grant issued: o_uop <= i_rslot[g], o_idx <= g, o_valid <= 1, ptr <= (g+1) mod NSLOT.
- Posedge, load & no eligible request: o_valid <= 0. o_uop and o_idx hold their stale values; ptr is unchanged.
- Posedge, ~load (held, stalled):
  - o_uop, o_idx and ptr hold.
  - If i_brkill[o_uop BrMask]=1, o_valid <= 0. Otherwise o_valid holds.
- Kill coincident with fire (o_valid & i_ready & kill): the transfer counts as issued. Downstream squashes it from its own i_brkill. The stage may still load a new winner in the same cycle.
- Back-to-back issue: with i_ready tied high, one uop issues per cycle, with a one-cycle latency from grant to o_valid.
- Stall: while o_valid=1 & i_ready=0, o_grant=0. Slots keep requesting and nothing is lost.
- Wrap: when ptr=NSLOT-1 and slot NSLOT-1 wins, ptr returns to 0.
- Reset mid-stall discards the held uop. No grant is asserted during reset.
- i_rslot of non-granted slots is don't-care.

Optional Feature:
- Macro QUEUE_ISSUE_SELECT_STATS_EN.
- When defined, two extra outputs are present:
  - o_issue_cnt [31:0]: increments on every cycle where o_valid & i_ready.
  - o_stall_cnt [31:0]: increments on every cycle where o_valid & ~i_ready & |i_request.
  - Both reset to 0 asynchronously, wrap at 2^32, and saturate neither.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package/header holds the width constants (WIDTH_REG, WIDTH_TAG, WIDTH_BRM, WIDTH_O) and the slot-word field offsets, so the slot, select and execute stages slice the word identically.
- One sub-module, rr_arbiter: purely combinational rotate-priority-rotate. Inputs eligible[NSLOT] and ptr; outputs one-hot grant, index and any-valid.
- The issue register, pointer and kill logic live in queue_issue_select.

Test Plan:
1. Reset: i_request=8'hFF with i_rst_n=0 → o_grant=0, o_valid=0. After release, the first cycle gives o_grant=8'h01, and next cycle o_idx=0 and o_valid=1.
2. Round-robin: i_request=8'b1010_0100, i_ready=1 constant → grants 8'h04, 8'h20, 8'h80, 8'h04 on successive cycles, with o_idx following 2, 5, 7, 2.
3. Stall: o_valid=1, i_ready=0 for 3 cycles with requests pending → o_grant=0, o_uop stable. Raise i_ready → fire and new grant in the same cycle.
4. Branch kill of slot: slot 3 (only requester) has BrMask=5 and i_brkill=8'h20 → o_grant=0, o_valid falls to 0 next cycle.
5. Branch kill of held uop: held BrMask=2, i_ready=0, i_brkill=8'h04 → o_valid=0 next cycle. Repeat with i_ready=1 → counted as issued.
6. Wrap and stats: ptr=7, requests on slots 7 and 0 → grant 7, then 0. With QUEUE_ISSUE_SELECT_STATS_EN, o_issue_cnt=2 and o_stall_cnt=0 afterwards.

Source files
------------

// File: rtl/queue_issue_select_pkg.sv
// Shared widths and slot-word field layout for the issue-queue slot, select and execute stages.
// Word layout, MSB to LSB: {BrMask, Tag, RD, RT, RS, val[1:0]}.
package queue_issue_select_pkg;

   localparam int NSLOT_DEF = 8;
   localparam int WIDTH_REG = 5;
   localparam int WIDTH_TAG = 3;
   localparam int WIDTH_BRM = 3;
   localparam int WIDTH_O   = WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 2;
   localparam int NBRK      = 2 ** WIDTH_BRM;

   localparam int OFF_VAL = 0;
   localparam int OFF_RS  = OFF_VAL + 2;
   localparam int OFF_RT  = OFF_RS + WIDTH_REG;
   localparam int OFF_RD  = OFF_RT + WIDTH_REG;
   localparam int OFF_TAG = OFF_RD + WIDTH_REG;
   localparam int OFF_BRM = OFF_TAG + WIDTH_TAG;

   typedef logic [WIDTH_O-1:0]   slot_word_t;
   typedef logic [WIDTH_BRM-1:0] brmask_t;

   function automatic brmask_t brmask_of(slot_word_t w);
      return brmask_t'(w >> OFF_BRM);
   endfunction

endpackage

// File: rtl/queue_issue_select_if.sv
// Slot-side and downstream-side signals of the select stage.
// Handshake: o_uop/o_idx transfer on a cycle where o_valid & i_ready; o_valid never depends on i_ready.
interface queue_issue_select_if
   import queue_issue_select_pkg::*;
#(
   parameter int NSLOT = NSLOT_DEF
) ();

   localparam int WIDTH_IDX = $clog2(NSLOT);

   logic [NSLOT-1:0]         i_request;
   logic [NSLOT*WIDTH_O-1:0] i_rslot;
   logic [NBRK-1:0]          i_brkill;
   logic                     i_ready;
   logic [NSLOT-1:0]         o_grant;
   logic                     o_valid;
   logic [WIDTH_O-1:0]       o_uop;
   logic [WIDTH_IDX-1:0]     o_idx;

   modport master (
      output i_request, i_rslot, i_brkill, i_ready,
      input  o_grant, o_valid, o_uop, o_idx
   );

   modport slave (
      input  i_request, i_rslot, i_brkill, i_ready,
      output o_grant, o_valid, o_uop, o_idx
   );

endinterface

// File: rtl/queue_issue_select_rr_arbiter.sv
// Combinational rotate-priority-rotate arbiter: lowest set bit at or above i_ptr wins, wrapping.
module rr_arbiter #(
   parameter  int NSLOT     = 8,
   localparam int WIDTH_IDX = $clog2(NSLOT)
) (
   input  logic [NSLOT-1:0]     i_eligible,
   input  logic [WIDTH_IDX-1:0] i_ptr,
   output logic [NSLOT-1:0]     o_grant,
   output logic [WIDTH_IDX-1:0] o_idx,
   output logic                 o_any
);

   logic [NSLOT-1:0]     rot;
   logic [WIDTH_IDX-1:0] rot_idx;

   always_comb begin
      rot     = '0;
      rot_idx = '0;
      o_grant = '0;
      // Rotate so the pointer slot lands at bit 0; index arithmetic wraps naturally.
      for (int k = 0; k < NSLOT; k++) begin
         rot[k] = i_eligible[WIDTH_IDX'(k) + i_ptr];
      end
      for (int k = NSLOT - 1; k >= 0; k--) begin
         if (rot[k]) rot_idx = WIDTH_IDX'(k);
      end
      o_any = |i_eligible;
      o_idx = rot_idx + i_ptr;
      if (o_any) o_grant[o_idx] = 1'b1;
   end

endmodule

// File: rtl/queue_issue_select.sv
// Issue select stage: round-robin pick among requesting slots into a registered issue slot with branch kill.
// Optional QUEUE_ISSUE_SELECT_STATS_EN adds o_issue_cnt / o_stall_cnt counters.
module queue_issue_select
   import queue_issue_select_pkg::*;
#(
   parameter  int NSLOT     = NSLOT_DEF,
   localparam int WIDTH_IDX = $clog2(NSLOT)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   queue_issue_select_if.slave  bus
`ifdef QUEUE_ISSUE_SELECT_STATS_EN
   ,
   output logic [31:0]          o_issue_cnt,
   output logic [31:0]          o_stall_cnt
`endif
);

   slot_word_t           words [NSLOT];
   logic [NSLOT-1:0]     eligible;
   logic [NSLOT-1:0]     arb_grant;
   logic [WIDTH_IDX-1:0] arb_idx;
   logic                 arb_any;

   logic                 valid_q;
   slot_word_t           uop_q;
   logic [WIDTH_IDX-1:0] idx_q;
   logic [WIDTH_IDX-1:0] ptr_q;

   logic                 load;
   logic                 grant_en;
   logic                 held_kill;

   always_comb begin
      for (int k = 0; k < NSLOT; k++) begin
         words[k]    = bus.i_rslot[k*WIDTH_O +: WIDTH_O];
         // A slot whose branch dies this cycle must not win arbitration.
         eligible[k] = bus.i_request[k] & ~bus.i_brkill[brmask_of(words[k])];
      end
   end

   rr_arbiter #(.NSLOT(NSLOT)) u_arb (
      .i_eligible (eligible),
      .i_ptr      (ptr_q),
      .o_grant    (arb_grant),
      .o_idx      (arb_idx),
      .o_any      (arb_any)
   );

   assign load      = ~valid_q | bus.i_ready;
   assign grant_en  = load & arb_any;
   assign held_kill = bus.i_brkill[brmask_of(uop_q)];

   // Reset is folded in so no slot sees a grant while the stage is held in reset.
   assign bus.o_grant = (grant_en & i_rst_n) ? arb_grant : '0;
   assign bus.o_valid = valid_q;
   assign bus.o_uop   = uop_q;
   assign bus.o_idx   = idx_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         uop_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else if (grant_en) begin
         valid_q <= 1'b1;
         uop_q   <= words[arb_idx];
         idx_q   <= arb_idx;
         ptr_q   <= arb_idx + 1'b1;
      end else if (load) begin
         valid_q <= 1'b0;
      end else if (held_kill) begin
         // Stalled uop squashed in place; uop/idx keep their stale contents.
         valid_q <= 1'b0;
      end
   end

`ifdef QUEUE_ISSUE_SELECT_STATS_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_issue_cnt <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (valid_q & bus.i_ready) o_issue_cnt <= o_issue_cnt + 32'd1;
         if (valid_q & ~bus.i_ready & (|bus.i_request)) o_stall_cnt <= o_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_queue_issue_select.sv
// Directed + random bench for queue_issue_select against a slot-list reference model.
module tb_queue_issue_select;
   import queue_issue_select_pkg::*;

   localparam int NS = NSLOT_DEF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   queue_issue_select_if #(.NSLOT(NS)) bus ();

`ifdef QUEUE_ISSUE_SELECT_STATS_EN
   logic [31:0] issue_cnt;
   logic [31:0] stall_cnt;
`endif

   queue_issue_select #(.NSLOT(NS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
`ifdef QUEUE_ISSUE_SELECT_STATS_EN
      ,
      .o_issue_cnt (issue_cnt),
      .o_stall_cnt (stall_cnt)
`endif
   );

   // Stimulus state
   logic [WIDTH_O-1:0] slot_w [NS];
   logic [NS-1:0]      req;
   logic [NBRK-1:0]    brk;
   logic               rdy;

   // Reference model state
   int                 m_ptr;
   bit                 m_valid;
   logic [WIDTH_O-1:0] m_uop;
   int                 m_idx;
   logic [31:0]        m_issue;
   logic [31:0]        m_stall;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int mask_of(logic [WIDTH_O-1:0] w);
      return int'(w >> OFF_BRM) % NBRK;
   endfunction

   function automatic logic [WIDTH_O-1:0] mk_word(int brm);
      logic [WIDTH_O-1:0] w;
      w = WIDTH_O'($urandom) % (WIDTH_O'(1) << OFF_BRM);
      return w + (WIDTH_O'(brm) << OFF_BRM);
   endfunction

   // Winner by the plain rule: first requesting, non-killed slot counting up from ptr.
   function automatic int model_winner();
      for (int s = 0; s < NS; s++) begin
         int k;
         k = (m_ptr + s) % NS;
         if (req[k] && !brk[mask_of(slot_w[k])]) return k;
      end
      return -1;
   endfunction

   function automatic logic [NS-1:0] model_grant();
      int w;
      w = model_winner();
      if (!rst_n || !(!m_valid || rdy) || w < 0) return '0;
      return NS'(1) << w;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 0;
      m_uop   = '0;
      m_idx   = 0;
      m_issue = '0;
      m_stall = '0;
   endtask

   task automatic model_clock();
      int w;
      bit can_load;
      if (!rst_n) return;
      w = model_winner();
      can_load = !m_valid || rdy;
      if (m_valid && rdy) m_issue = m_issue + 1;
      if (m_valid && !rdy && req != 0) m_stall = m_stall + 1;
      if (can_load && w >= 0) begin
         m_uop   = slot_w[w];
         m_idx   = w;
         m_valid = 1;
         m_ptr   = (w + 1) % NS;
      end else if (can_load) begin
         m_valid = 0;
      end else if (brk[mask_of(m_uop)]) begin
         m_valid = 0;
      end
   endtask

   task automatic apply();
      for (int k = 0; k < NS; k++) bus.i_rslot[k*WIDTH_O +: WIDTH_O] = slot_w[k];
      bus.i_request = req;
      bus.i_brkill  = brk;
      bus.i_ready   = rdy;
   endtask

   // Called at a negedge: drive, check the model's view, then advance one clock.
   task automatic step(string tag, int xg = -1);
      apply();
      #1;
      check({tag, ".grant"}, 64'(bus.o_grant), 64'(model_grant()));
      check({tag, ".valid"}, 64'(bus.o_valid), 64'(m_valid));
      check({tag, ".uop"},   64'(bus.o_uop),   64'(m_uop));
      check({tag, ".idx"},   64'(bus.o_idx),   64'(m_idx));
      if (xg >= 0) check({tag, ".grant_dir"}, 64'(bus.o_grant), 64'(xg));
`ifdef QUEUE_ISSUE_SELECT_STATS_EN
      check({tag, ".issue_cnt"}, 64'(issue_cnt), 64'(m_issue));
      check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`endif
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic set_reset(logic v);
      rst_n = v;
      if (!v) model_reset();
   endtask

   task automatic pulse_reset();
      set_reset(1'b0);
      step("rst");
      set_reset(1'b1);
   endtask

   logic [31:0] base_issue;
   logic [31:0] base_stall;

   initial begin
      model_reset();
      for (int k = 0; k < NS; k++) slot_w[k] = mk_word(k);
      req = '0;
      brk = '0;
      rdy = 1'b1;
      apply();
      @(negedge clk);

      // Reset with every slot requesting, then first grant after release
      req = 8'hFF;
      set_reset(1'b0);
      step("rst_hold", 8'h00);
      step("rst_hold2", 8'h00);
      set_reset(1'b1);
      step("rel_first", 8'h01);
      step("rel_second", 8'h02);
      check("rel_idx0", 64'(bus.o_idx), 64'(1));

      // Round robin over slots 2, 5, 7
      pulse_reset();
      req = 8'b1010_0100;
      rdy = 1'b1;
      step("rr0", 8'h04);
      step("rr1", 8'h20);
      step("rr2", 8'h80);
      step("rr3", 8'h04);

      // Stall with requests pending, then release
      rdy = 1'b0;
      step("stall0", 8'h00);
      step("stall1", 8'h00);
      step("stall2", 8'h00);
      check("stall_uop", 64'(bus.o_uop), 64'(slot_w[2]));
      rdy = 1'b1;
      step("unstall", 8'h20);

      // Kill of the only requesting slot
      req = '0;
      step("drain");
      slot_w[3] = mk_word(5);
      req = 8'h08;
      brk = 8'h20;
      step("kill_slot", 8'h00);
      step("kill_slot_after", 8'h00);
      check("kill_slot_valid", 64'(bus.o_valid), 64'(0));

      // Kill of a held uop while stalled, then coincident with fire
      brk = '0;
      slot_w[1] = mk_word(2);
      req = 8'h02;
      step("held_load", 8'h02);
      req = '0;
      rdy = 1'b0;
      brk = 8'h04;
      step("held_kill");
      step("held_kill_after");
      check("held_kill_valid", 64'(bus.o_valid), 64'(0));
      brk = '0;
      rdy = 1'b1;
      req = 8'h02;
      step("fire_load");
      req = '0;
      brk = 8'h04;
      step("fire_kill");
      brk = '0;
      step("fire_kill_after");

      // Wrap from slot 7 back to slot 0
      pulse_reset();
      req = 8'h40;
      step("to_ptr7", 8'h40);
      req = '0;
      step("to_ptr7_drain");
      base_issue = m_issue;
      base_stall = m_stall;
      req = 8'h81;
      step("wrap7", 8'h80);
      step("wrap0", 8'h01);
      req = '0;
      step("wrap_drain");
      step("wrap_idle");
`ifdef QUEUE_ISSUE_SELECT_STATS_EN
      check("wrap_issue_delta", 64'(issue_cnt - base_issue), 64'(2));
      check("wrap_stall_delta", 64'(stall_cnt - base_stall), 64'(0));
`endif

      // Reset in the middle of a stall discards the held uop
      req = 8'h10;
      step("mid_load");
      rdy = 1'b0;
      step("mid_stall");
      set_reset(1'b0);
      step("mid_rst", 8'h00);
      set_reset(1'b1);
      rdy = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NS; k++) slot_w[k] = mk_word(int'($urandom_range(0, NBRK - 1)));
         req = NS'($urandom);
         brk = ($urandom_range(0, 3) == 0) ? (NBRK'(1) << $urandom_range(0, NBRK - 1)) : '0;
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) set_reset(1'b0);
         step("rand");
         if (!rst_n) set_reset(1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
